// File: rtl/lcd_segment_scanner.sv
// LCD segment scanner: steps lcd_h through the four H rows, samples the segment cache
// at each row and hands assembled 128-bit frames to the renderer over valid/ready,
// with one pending slot to absorb renderer stalls.
module lcd_segment_scanner #(
  parameter int unsigned SCAN_DIV      = 16,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         lcd_blank,
  output logic [1:0]   lcd_h,
  input  logic [15:0]  segment_a,
  input  logic [15:0]  segment_b,
  output logic [127:0] frame_data,
  output logic         frame_valid,
  input  logic         frame_ready,
  output logic [7:0]   drop_count
);

  localparam int unsigned DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DivW-1:0] r_div;
  logic [1:0]      r_lcd_h;
  logic            r_restart;
  logic [127:0]    r_shadow;
  logic            r_done;
  logic [127:0]    r_pend;
  logic            r_pend_full;
  logic [127:0]    r_data;
  logic            r_valid;
  logic [7:0]      r_drop;

  logic            w_wrap;
  logic            w_sample;
  logic            w_out_free;
  logic [15:0]     w_row_a;
  logic [15:0]     w_row_b;

  assign w_wrap     = (r_div == DivW'(SCAN_DIV - 1));
  // The first enabled edge after an abort only re-homes the scan; no sample on it.
  assign w_sample   = enable && !r_restart && (r_div == DivW'(SETTLE_CYCLES));
  assign w_out_free = !r_valid || frame_ready;
  assign w_row_a    = segment_a & {16{~lcd_blank}};
  assign w_row_b    = segment_b & {16{~lcd_blank}};

  // Row divider and H select; an enable drop mid-scan arms a restart from H=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_lcd_h   <= 2'd0;
      r_restart <= 1'b0;
    end else if (enable) begin
      if (r_restart) begin
        r_div     <= '0;
        r_lcd_h   <= 2'd0;
        r_restart <= 1'b0;
      end else if (w_wrap) begin
        r_div   <= '0;
        r_lcd_h <= r_lcd_h + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end else if ((r_div != '0) || (r_lcd_h != 2'd0)) begin
      r_restart <= 1'b1;
    end
  end

  // Shadow frame capture; done pulses for one cycle after the H=3 sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_sample && (r_lcd_h == 2'd3);
      if (enable && r_restart) begin
        r_shadow <= '0;
      end else if (w_sample) begin
        r_shadow[{r_lcd_h, 5'd0} +: 16]        <= w_row_a;
        r_shadow[{r_lcd_h, 5'd0} + 7'd16 +: 16] <= w_row_b;
      end
    end
  end

  // Output and pending slots: commit the shadow on done, otherwise drain on handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_drop      <= 8'd0;
    end else if (r_done) begin
      if (w_out_free) begin
        r_valid <= 1'b1;
        if (r_pend_full) begin
          r_data <= r_pend;
          r_pend <= r_shadow;
        end else begin
          r_data <= r_shadow;
        end
      end else begin
        r_pend      <= r_shadow;
        r_pend_full <= 1'b1;
        if (r_pend_full && (r_drop != 8'hFF)) begin
          r_drop <= r_drop + 8'd1;
        end
      end
    end else if (r_valid && frame_ready) begin
      if (r_pend_full) begin
        r_data      <= r_pend;
        r_pend_full <= 1'b0;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign lcd_h       = r_lcd_h;
  assign frame_data  = r_data;
  assign frame_valid = r_valid;
  assign drop_count  = r_drop;

endmodule
